// File: rtl/mining_pkg.sv
// Shared sizes and FSM state encoding for the nonce search controller.
// Pass-2 states exist only when DOUBLE_HASH_EN is defined.
package mining_pkg;
    localparam int unsigned MSG_SIZE    = 640;
    localparam int unsigned HEADER_SIZE = 608;
    localparam int unsigned NONCE_SIZE  = 32;
    localparam int unsigned DIGEST_SIZE = 256;

    typedef enum logic [3:0] {
        IDLE,
        LOAD,
        BEGIN1,
        GUARD1,
        WAIT1,
`ifdef DOUBLE_HASH_EN
        BEGIN2,
        GUARD2,
        WAIT2,
`endif
        CHECK,
        DONE
    } state_e;
endpackage

// File: rtl/hash_target_cmp.sv
// Unsigned 256-bit digest-versus-target comparison; hit when digest < target.
module hash_target_cmp
    import mining_pkg::*;
(
    input  logic [DIGEST_SIZE-1:0] digest_i,
    input  logic [DIGEST_SIZE-1:0] target_i,
    output logic                   hit_o
);
    always_comb begin
        hit_o = (digest_i < target_i);
    end
endmodule

// File: rtl/nonce_search_ctrl.sv
// Walks a nonce range, launching SHA passes and stopping at the first digest below target.
// Define DOUBLE_HASH_EN to chain a second SHA pass over the first digest.
module nonce_search_ctrl #(
    parameter int unsigned MSG_SIZE    = 640,
    parameter int unsigned HEADER_SIZE = 608
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                start,
    input  logic                                abort,
    input  logic [HEADER_SIZE-1:0]              header,
    input  logic [mining_pkg::NONCE_SIZE-1:0]   nonce_start,
    input  logic [mining_pkg::NONCE_SIZE-1:0]   nonce_end,
    input  logic [mining_pkg::DIGEST_SIZE-1:0]  target,
    output logic [MSG_SIZE-1:0]                 sha_msg,
    output logic                                sha_begin,
    input  logic                                sha_complete,
    input  logic [mining_pkg::DIGEST_SIZE-1:0]  sha_digest,
    output logic                                busy,
    output logic                                done,
    output logic                                found,
    output logic [mining_pkg::NONCE_SIZE-1:0]   found_nonce,
    output logic [mining_pkg::DIGEST_SIZE-1:0]  found_hash,
    output logic [mining_pkg::NONCE_SIZE-1:0]   attempts
);
    import mining_pkg::*;

    state_e                 state_q, state_d;
    logic [HEADER_SIZE-1:0] header_q, header_d;
    logic [NONCE_SIZE-1:0]  cur_nonce_q, cur_nonce_d;
    logic [NONCE_SIZE-1:0]  nonce_end_q, nonce_end_d;
    logic [NONCE_SIZE-1:0]  attempts_q, attempts_d;
    logic [NONCE_SIZE-1:0]  found_nonce_q, found_nonce_d;
    logic [DIGEST_SIZE-1:0] target_q, target_d;
    logic [DIGEST_SIZE-1:0] found_hash_q, found_hash_d;
    logic                   found_q, found_d;
    logic                   hit, launch, last_nonce;
`ifdef DOUBLE_HASH_EN
    logic [DIGEST_SIZE-1:0] digest1_q, digest1_d;
    logic                   pass2_q, pass2_d;
`endif

    hash_target_cmp u_cmp (
        .digest_i (sha_digest),
        .target_i (target_q),
        .hit_o    (hit)
    );

    assign launch     = (state_q == IDLE) && start && !abort;
    assign last_nonce = (cur_nonce_q == nonce_end_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (state_q != IDLE && abort) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:   if (launch) state_d = LOAD;
                LOAD:   state_d = BEGIN1;
                BEGIN1: state_d = GUARD1;
                GUARD1: state_d = WAIT1;
`ifdef DOUBLE_HASH_EN
                WAIT1:  if (sha_complete) state_d = BEGIN2;
                BEGIN2: state_d = GUARD2;
                GUARD2: state_d = WAIT2;
                WAIT2:  if (sha_complete) state_d = CHECK;
`else
                WAIT1:  if (sha_complete) state_d = CHECK;
`endif
                CHECK:  state_d = (hit || last_nonce) ? DONE : LOAD;
                DONE:   state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        busy      = (state_q != IDLE) && (state_q != DONE);
        done      = (state_q == DONE);
`ifdef DOUBLE_HASH_EN
        sha_begin = (state_q == BEGIN1) || (state_q == BEGIN2);
        sha_msg   = pass2_q ? {{(MSG_SIZE - DIGEST_SIZE){1'b0}}, digest1_q}
                            : {header_q, cur_nonce_q};
`else
        sha_begin = (state_q == BEGIN1);
        sha_msg   = {header_q, cur_nonce_q};
`endif
    end

    // Abort suppresses every datapath update, so results freeze at their pre-abort values.
    always_comb begin
        header_d      = header_q;
        cur_nonce_d   = cur_nonce_q;
        nonce_end_d   = nonce_end_q;
        target_d      = target_q;
        attempts_d    = attempts_q;
        found_d       = found_q;
        found_nonce_d = found_nonce_q;
        found_hash_d  = found_hash_q;
`ifdef DOUBLE_HASH_EN
        digest1_d     = digest1_q;
        pass2_d       = pass2_q;
`endif
        if (launch) begin
            header_d      = header;
            cur_nonce_d   = nonce_start;
            nonce_end_d   = nonce_end;
            target_d      = target;
            attempts_d    = '0;
            found_d       = 1'b0;
            found_nonce_d = '0;
            found_hash_d  = '0;
`ifdef DOUBLE_HASH_EN
            pass2_d       = 1'b0;
`endif
        end
`ifdef DOUBLE_HASH_EN
        if (state_q == WAIT1 && sha_complete && !abort) begin
            digest1_d = sha_digest;
            pass2_d   = 1'b1;
        end
`endif
        if (state_q == CHECK && !abort) begin
            attempts_d = attempts_q + 1'b1;
            if (hit) begin
                found_d       = 1'b1;
                found_nonce_d = cur_nonce_q;
                found_hash_d  = sha_digest;
            end else if (!last_nonce) begin
                cur_nonce_d = cur_nonce_q + 1'b1;
`ifdef DOUBLE_HASH_EN
                pass2_d     = 1'b0;
`endif
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            header_q      <= '0;
            cur_nonce_q   <= '0;
            nonce_end_q   <= '0;
            target_q      <= '0;
            attempts_q    <= '0;
            found_q       <= 1'b0;
            found_nonce_q <= '0;
            found_hash_q  <= '0;
`ifdef DOUBLE_HASH_EN
            digest1_q     <= '0;
            pass2_q       <= 1'b0;
`endif
        end else begin
            header_q      <= header_d;
            cur_nonce_q   <= cur_nonce_d;
            nonce_end_q   <= nonce_end_d;
            target_q      <= target_d;
            attempts_q    <= attempts_d;
            found_q       <= found_d;
            found_nonce_q <= found_nonce_d;
            found_hash_q  <= found_hash_d;
`ifdef DOUBLE_HASH_EN
            digest1_q     <= digest1_d;
            pass2_q       <= pass2_d;
`endif
        end
    end

    assign found       = found_q;
    assign found_nonce = found_nonce_q;
    assign found_hash  = found_hash_q;
    assign attempts    = attempts_q;
endmodule

// File: tb/tb_nonce_search_ctrl.sv
// Scoreboard bench for nonce_search_ctrl with a behavioural SHA stub (T=5, digest={~msg[31:0],0}).
// Honours DOUBLE_HASH_EN when defined for the build.
module tb_nonce_search_ctrl;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic         abort = 1'b0;
    logic [607:0] header = '0;
    logic [31:0]  ns = '0;
    logic [31:0]  ne = '0;
    logic [255:0] tgt = '0;
    logic [639:0] sha_msg;
    logic         sha_begin;
    logic         sha_complete = 1'b0;
    logic [255:0] sha_digest = '0;
    logic         busy, done, found;
    logic [31:0]  found_nonce, attempts;
    logic [255:0] found_hash;

`ifdef DOUBLE_HASH_EN
    localparam int PER_NONCE = 16;
`else
    localparam int PER_NONCE = 9;
`endif

    always #5 clk = ~clk;

    nonce_search_ctrl #(.MSG_SIZE(640), .HEADER_SIZE(608)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .abort        (abort),
        .header       (header),
        .nonce_start  (ns),
        .nonce_end    (ne),
        .target       (tgt),
        .sha_msg      (sha_msg),
        .sha_begin    (sha_begin),
        .sha_complete (sha_complete),
        .sha_digest   (sha_digest),
        .busy         (busy),
        .done         (done),
        .found        (found),
        .found_nonce  (found_nonce),
        .found_hash   (found_hash),
        .attempts     (attempts)
    );

    function automatic logic [255:0] model_sha(input logic [639:0] m);
        return {~m[31:0], 224'd0};
    endfunction

    // SHA stub: complete stays high one cycle past begin to exercise the guard cycle.
    logic [639:0] stub_msg = '0;
    int           stub_cnt = 0;
    logic         stub_drop = 1'b0;
    always @(posedge clk) begin
        if (sha_begin) begin
            stub_msg  <= sha_msg;
            stub_cnt  <= 5;
            stub_drop <= 1'b1;
        end else begin
            if (stub_drop) begin
                sha_complete <= 1'b0;
                stub_drop    <= 1'b0;
            end
            if (stub_cnt > 0) begin
                stub_cnt <= stub_cnt - 1;
                if (stub_cnt == 1) begin
                    sha_complete <= 1'b1;
                    sha_digest   <= model_sha(stub_msg);
                end
            end
        end
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [639:0] obs, input logic [639:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    typedef struct {
        logic [639:0] msg;
        bit           first;
    } beg_t;
    typedef struct {
        logic         fnd;
        logic [31:0]  nonce;
        logic [255:0] hash;
        logic [31:0]  att;
    } res_t;

    beg_t beg_q[$];
    res_t res_q[$];
    int   cyc = 0;
    int   last_first = -1;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin : monitor
        beg_t b;
        res_t r;
        if (sha_begin) begin
            if (beg_q.size() == 0) begin
                check_eq("spurious_begin", 1, 0);
            end else begin
                b = beg_q.pop_front();
                check_eq("sha_msg", sha_msg, b.msg);
                if (b.first) begin
                    if (last_first >= 0) check_eq("nonce_period", cyc - last_first, PER_NONCE);
                    last_first = cyc;
                end
            end
        end
        if (done) begin
            if (res_q.size() == 0) begin
                check_eq("spurious_done", 1, 0);
            end else begin
                r = res_q.pop_front();
                check_eq("found", found, r.fnd);
                check_eq("found_nonce", found_nonce, r.nonce);
                check_eq("found_hash", found_hash, r.hash);
                check_eq("attempts", attempts, r.att);
                check_eq("busy_at_done", busy, 0);
                check_eq("begins_left", beg_q.size(), 0);
            end
        end
    end

    task automatic launch(input logic [607:0] h, input logic [31:0] s, input logic [31:0] e,
                          input logic [255:0] t);
        logic [31:0]  n;
        logic [255:0] d1, fd;
        res_t         r;
        int           att;
        n = s;
        att = 0;
        r.fnd = 1'b0;
        r.nonce = '0;
        r.hash = '0;
        for (int k = 0; k < 1000; k++) begin
            d1 = model_sha({h, n});
            beg_q.push_back('{{h, n}, 1'b1});
`ifdef DOUBLE_HASH_EN
            beg_q.push_back('{{384'd0, d1}, 1'b0});
            fd = model_sha({384'd0, d1});
`else
            fd = d1;
`endif
            att++;
            if (fd < t) begin
                r.fnd = 1'b1;
                r.nonce = n;
                r.hash = fd;
                break;
            end
            if (n == e) break;
            n = n + 1;
        end
        r.att = att;
        res_q.push_back(r);
        last_first = -1;
        @(negedge clk);
        header = h;
        ns = s;
        ne = e;
        tgt = t;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_eq("busy_rise", busy, 1);
    endtask

    task automatic wait_end();
        for (int k = 0; k < 5000; k++) begin
            @(negedge clk);
            if (res_q.size() == 0 && !busy) return;
        end
        check_eq("search_timeout", 1, 0);
    endtask

    task automatic wait_attempts(input logic [31:0] a);
        for (int k = 0; k < 2000; k++) begin
            @(negedge clk);
            if (attempts == a) return;
        end
        check_eq("attempts_timeout", attempts, a);
    endtask

    task automatic wait_begin();
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (sha_begin) return;
        end
        check_eq("begin_timeout", 1, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running, expected finish");
        $fatal(1);
    end

    logic [607:0] H;

    initial begin
        H = {19{32'hDEADBEEF}};
        repeat (3) @(negedge clk);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_found", found, 0);
        check_eq("rst_begin", sha_begin, 0);
        check_eq("rst_msg", sha_msg, 0);
        check_eq("rst_attempts", attempts, 0);
        rst = 1'b0;
        @(negedge clk);

        // first hit at nonce 8; a start pulse mid-search must be ignored
        launch(H, 32'd0, 32'd20, {32'hFFFFFFF8, 224'd0});
        repeat (20) @(negedge clk);
        header = ~H;
        ns = 32'd100;
        ne = 32'd200;
        tgt = '1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_end();

        launch(H, 32'd0, 32'd5, {32'hFFFFFFF8, 224'd0});
        wait_end();

        launch(H, 32'hFFFFFFFE, 32'd1, 256'd0);
        wait_end();

        launch(H, 32'd7, 32'd7, '1);
        wait_end();
        launch(H, 32'd3, 32'd3, 256'd0);
        wait_end();
        launch(H, 32'd4, 32'd6, {32'hFFFFFFFA, 224'd0});
        wait_end();

        // start together with abort in IDLE stays idle
        @(negedge clk);
        ns = 32'd0;
        ne = 32'd3;
        tgt = '1;
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        repeat (10) @(negedge clk);
        check_eq("start_abort_idle", busy, 0);

        // abort during WAIT1 of the second nonce
        launch(H, 32'd0, 32'd100, 256'd0);
        wait_attempts(32'd1);
        wait_begin();
        @(posedge clk);
        @(posedge clk);
        #1 abort = 1'b1;
        @(posedge clk);
        #1;
        check_eq("abort_busy", busy, 0);
        check_eq("abort_done", done, 0);
        abort = 1'b0;
        beg_q.delete();
        res_q.delete();
        repeat (40) @(negedge clk);
        check_eq("abort_found", found, 0);
        check_eq("abort_attempts", attempts, 1);
        check_eq("abort_idle", busy, 0);

        launch(H, 32'd10, 32'd12, {32'hFFFFFFF4, 224'd0});
        wait_end();

        // asynchronous reset in WAIT1
        launch(H, 32'd0, 32'd50, 256'd0);
        wait_attempts(32'd1);
        wait_begin();
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check_eq("mid_rst_busy", busy, 0);
        check_eq("mid_rst_done", done, 0);
        check_eq("mid_rst_found", found, 0);
        check_eq("mid_rst_begin", sha_begin, 0);
        check_eq("mid_rst_msg", sha_msg, 0);
        check_eq("mid_rst_attempts", attempts, 0);
        check_eq("mid_rst_fnonce", found_nonce, 0);
        check_eq("mid_rst_fhash", found_hash, 0);
        beg_q.delete();
        res_q.delete();
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);

        launch(H, 32'd0, 32'd20, {32'hFFFFFFF8, 224'd0});
        wait_end();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
